// File: rtl/lcd_bus_writer.sv
// HD44780-class LCD bus writer: one RS/data byte per handshake, programmable strobe timing,
// 8-bit or 4-bit bus, and a post-byte execution wait (long for clear/home).
module lcd_bus_writer #(
  parameter bit          BUS4        = 1'b0,
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_EN_HIGH   = 16,
  parameter int unsigned T_EN_LOW    = 32,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 80000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  typedef enum logic [2:0] {StIdle, StSetup, StEnHi, StEnLo, StExec} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nib_q, nib_d;
  logic             long_q, long_d;
  logic [3:0]       lo_q, lo_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic             lcd_en_q, lcd_en_d;
  logic             done_q, done_d;
  logic             accept;
  logic             cnt_last;

  assign accept = (state_q == StIdle) && in_valid;

  // Last cycle of the current timed state.
  always_comb begin
    cnt_last = 1'b0;
    unique case (state_q)
      StSetup: cnt_last = (cnt_q == CNT_W'(T_SETUP - 1));
      StEnHi:  cnt_last = (cnt_q == CNT_W'(T_EN_HIGH - 1));
      StEnLo:  cnt_last = (cnt_q == CNT_W'(T_EN_LOW - 1));
      StExec:  cnt_last = long_q ? (cnt_q == CNT_W'(T_EXEC_LONG - 1))
                                 : (cnt_q == CNT_W'(T_EXEC - 1));
      default: cnt_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      nib_q      <= 1'b0;
      long_q     <= 1'b0;
      lo_q       <= '0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nib_q      <= nib_d;
      long_q     <= long_d;
      lo_q       <= lo_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    long_d  = long_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StSetup;
          cnt_d   = '0;
          nib_d   = 1'b0;
          long_d  = !in_rs && (in_data[7:2] == 6'd0) && (in_data != 8'd0);
          lo_d    = in_data[3:0];
        end
      end
      StSetup: if (cnt_last) state_d = StEnHi;
      StEnHi:  if (cnt_last) state_d = (BUS4 && !nib_q) ? StEnLo : StExec;
      StEnLo: begin
        if (cnt_last) begin
          state_d = StSetup;
          nib_d   = 1'b1;
        end
      end
      StExec: begin
        if (cnt_last) begin
          state_d = StIdle;
          nib_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle) cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
  end

  // Registered pin values, computed from the next state so pins change with the state.
  always_comb begin
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_en_d   = (state_d == StEnHi);
    done_d     = (state_q == StExec) && cnt_last;
    if (accept) begin
      lcd_data_d = BUS4 ? {in_data[7:4], 4'h0} : in_data;
      lcd_rs_d   = in_rs;
    end else if ((state_q == StEnLo) && cnt_last) begin
      lcd_data_d = {lo_q, 4'h0};
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = !in_ready;
  assign done     = done_q;
  assign lcd_data = lcd_data_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_en   = lcd_en_q;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: 8-bit and 4-bit instances with short timings, plus one instance
// with default timings; expected pin waveforms derived from the timing arithmetic.
module tb_lcd_bus_writer;

  localparam int TS = 2, TH = 3, TL = 2, TE = 5, TEL = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] valid = '0;
  logic [2:0] rs_i = '0;
  logic [7:0] din [3];
  logic [2:0] ready, busy, done, en, rs_o, rw;
  logic [7:0] dout [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lcd_bus_writer #(
    .BUS4(1'b0), .T_SETUP(TS), .T_EN_HIGH(TH), .T_EN_LOW(TL), .T_EXEC(TE), .T_EXEC_LONG(TEL),
    .CNT_W(17)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[0]), .in_ready(ready[0]), .in_rs(rs_i[0]),
    .in_data(din[0]), .busy(busy[0]), .done(done[0]), .lcd_data(dout[0]), .lcd_rs(rs_o[0]),
    .lcd_rw(rw[0]), .lcd_en(en[0])
  );

  lcd_bus_writer #(
    .BUS4(1'b1), .T_SETUP(TS), .T_EN_HIGH(TH), .T_EN_LOW(TL), .T_EXEC(TE), .T_EXEC_LONG(TEL),
    .CNT_W(17)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[1]), .in_ready(ready[1]), .in_rs(rs_i[1]),
    .in_data(din[1]), .busy(busy[1]), .done(done[1]), .lcd_data(dout[1]), .lcd_rs(rs_o[1]),
    .lcd_rw(rw[1]), .lcd_en(en[1])
  );

  lcd_bus_writer dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[2]), .in_ready(ready[2]), .in_rs(rs_i[2]),
    .in_data(din[2]), .busy(busy[2]), .done(done[2]), .lcd_data(dout[2]), .lcd_rs(rs_o[2]),
    .lcd_rw(rw[2]), .lcd_en(en[2])
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_lat(input bit b4, input bit r, input logic [7:0] b,
                                   input int ts, input int th, input int tl,
                                   input int te, input int tel);
    bit lng;
    lng = !r && (b >= 8'd1) && (b <= 8'd3);
    return b4 ? (2 * ts + 2 * th + tl + (lng ? tel : te)) : (ts + th + (lng ? tel : te));
  endfunction

  // Called at a negedge; returns at a negedge after the byte has completed.
  task automatic xfer(input int d, input bit r, input logic [7:0] b, input int lat,
                      input bit b4, input int ts, input int th, input int tl);
    int n;
    bit x_en;
    logic [7:0] x_dat;
    n = 0;
    while (!ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", int'(ready[d]), 1);
    valid[d] = 1'b1;
    rs_i[d]  = r;
    din[d]   = b;
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
    rs_i[d]  = ~r;
    din[d]   = ~b;
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      x_en = (k >= ts && k < ts + th) ||
             (b4 && k >= 2 * ts + th + tl && k < 2 * ts + 2 * th + tl);
      if (!b4) x_dat = b;
      else if (k < ts + th + tl) x_dat = {b[7:4], 4'h0};
      else x_dat = {b[3:0], 4'h0};
      check("lcd_en", int'(en[d]), int'(x_en));
      check("lcd_data", int'(dout[d]), int'(x_dat));
      check("lcd_rs", int'(rs_o[d]), int'(r));
      check("lcd_rw", int'(rw[d]), 0);
      check("done", int'(done[d]), int'(k == lat));
      check("in_ready", int'(ready[d]), int'(k >= lat));
      check("busy", int'(busy[d]), int'(k < lat));
    end
  endtask

  typedef struct {
    bit         rs;
    logic [7:0] data;
    int         lat8;
    int         lat4;
  } vec_t;

  vec_t tbl [8];
  logic [7:0] b2b [3];

  initial begin
    tbl[0] = '{rs: 1'b1, data: 8'h41, lat8: 10, lat4: 17};
    tbl[1] = '{rs: 1'b0, data: 8'h01, lat8: 25, lat4: 32};
    tbl[2] = '{rs: 1'b0, data: 8'h38, lat8: 10, lat4: 17};
    tbl[3] = '{rs: 1'b1, data: 8'hA5, lat8: 10, lat4: 17};
    tbl[4] = '{rs: 1'b0, data: 8'h02, lat8: 25, lat4: 32};
    tbl[5] = '{rs: 1'b0, data: 8'h03, lat8: 25, lat4: 32};
    tbl[6] = '{rs: 1'b0, data: 8'h04, lat8: 10, lat4: 17};
    tbl[7] = '{rs: 1'b1, data: 8'h01, lat8: 10, lat4: 17};
    b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33;
    for (int i = 0; i < 3; i++) din[i] = '0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", int'(ready[i]), 1);
      check("rst_busy", int'(busy[i]), 0);
      check("rst_done", int'(done[i]), 0);
      check("rst_en", int'(en[i]), 0);
      check("rst_data", int'(dout[i]), 0);
      check("rst_rs", int'(rs_o[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      xfer(0, tbl[i].rs, tbl[i].data, tbl[i].lat8, 1'b0, TS, TH, TL);
      xfer(1, tbl[i].rs, tbl[i].data, tbl[i].lat4, 1'b1, TS, TH, TL);
    end

    for (int i = 0; i < 40; i++) begin
      int d;
      bit r;
      logic [7:0] b;
      d = i % 2;
      r = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      xfer(d, r, b, model_lat(d == 1, r, b, TS, TH, TL, TE, TEL), d == 1, TS, TH, TL);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // in_valid held high: each byte accepted on the done cycle of the previous one.
    valid[0] = 1'b1;
    rs_i[0]  = 1'b1;
    din[0]   = b2b[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k <= 10; k++) begin
        @(negedge clk);
        check("b2b_data", int'(dout[0]), int'(b2b[i]));
        check("b2b_done", int'(done[0]), int'(k == 10));
        check("b2b_ready", int'(ready[0]), int'(k >= 10));
        if (k == 4) din[0] = 8'hE7;
        if (k == 10) begin
          if (i < 2) din[0] = b2b[i + 1];
          else valid[0] = 1'b0;
        end
      end
    end
    @(negedge clk);
    check("b2b_end_done", int'(done[0]), 0);
    check("b2b_end_ready", int'(ready[0]), 1);

    // Asynchronous reset in the middle of the enable pulse.
    valid[0] = 1'b1;
    rs_i[0]  = 1'b1;
    din[0]   = 8'h5A;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_en", int'(en[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_en", int'(en[0]), 0);
    check("async_ready", int'(ready[0]), 1);
    check("async_data", int'(dout[0]), 0);
    check("async_done", int'(done[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("post_rst_done", int'(done[0]), 0);
      check("post_rst_ready", int'(ready[0]), 1);
    end
    xfer(0, 1'b1, 8'h41, 10, 1'b0, TS, TH, TL);

    // Default timings: clear/home long wait.
    xfer(2, 1'b0, 8'h02, 4 + 16 + 80000, 1'b0, 4, 16, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
